// File: rtl/writeback_stage_if.sv
// Memory-stage to write-back bundle: instruction/result inputs, decode read ports,
// and the commit/status outputs of the write-back stage.
interface writeback_stage_if;
  logic        wb_valid;
  logic [31:0] IR;
  logic [31:0] dataout;
  logic [31:0] ALUResult;
  logic [4:0]  RS1_addr;
  logic [4:0]  RS2_addr;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [63:0] instret;
  logic        illegal_op;

  modport master (
    output wb_valid, IR, dataout, ALUResult, RS1_addr, RS2_addr,
    input  RD1, RD2, commit_valid, commit_rd, commit_data, instret, illegal_op
  );

  modport slave (
    input  wb_valid, IR, dataout, ALUResult, RS1_addr, RS2_addr,
    output RD1, RD2, commit_valid, commit_rd, commit_data, instret, illegal_op
  );
endinterface

// File: rtl/writeback_stage.sv
// RISC-V write-back stage: selects the result, owns the 32x32 register file with
// same-cycle bypass on both read ports, and tracks commit trace, instret and illegal opcodes.
module writeback_stage (
  input  logic             clk,
  input  logic             rst,
  writeback_stage_if.slave wb
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic        legal_op;
  logic        writes_rd;
  logic        sel_load;
  logic [4:0]  rd;
  logic [31:0] wb_value;
  logic        wr_en;
  logic        retire;

  logic [31:0] regs_reg [1:31];
  logic        commit_valid_reg;
  logic [4:0]  commit_rd_reg;
  logic [31:0] commit_data_reg;
  logic [63:0] instret_reg;
  logic        illegal_op_reg;

  // Only opcode and rd fields matter at write-back.
  logic unused_ir_hi;
  assign unused_ir_hi = ^wb.IR[31:12];

  always_comb begin
    legal_op  = 1'b0;
    writes_rd = 1'b0;
    sel_load  = 1'b0;
    case (wb.IR[6:0])
      OP_LOAD: begin
        legal_op  = 1'b1;
        writes_rd = 1'b1;
        sel_load  = 1'b1;
      end
      OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
        legal_op  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_STORE, OP_BRANCH, OP_SYSTEM: legal_op = 1'b1;
      default: ;
    endcase
  end

  assign rd       = wb.IR[11:7];
  assign wb_value = sel_load ? wb.dataout : wb.ALUResult;
  // Gating with rst keeps the bypass silent (RDn = 0) while reset is held.
  assign wr_en    = rst & wb.wb_valid & writes_rd & (rd != 5'd0);
  assign retire   = rst & wb.wb_valid & legal_op;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          regs_reg[gi] <= 32'd0;
        end else if (wr_en && (rd == 5'(gi))) begin
          regs_reg[gi] <= wb_value;
        end
      end
    end
  endgenerate

  logic [4:0]  rs_addr [2];
  logic [31:0] rs_data [2];
  assign rs_addr[0] = wb.RS1_addr;
  assign rs_addr[1] = wb.RS2_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        rs_data[gi] = 32'd0;
        if (rs_addr[gi] != 5'd0) begin
          if (wr_en && (rd == rs_addr[gi])) begin
            rs_data[gi] = wb_value;
          end else begin
            rs_data[gi] = regs_reg[rs_addr[gi]];
          end
        end
      end
    end
  endgenerate

  assign wb.RD1 = rs_data[0];
  assign wb.RD2 = rs_data[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_valid_reg <= 1'b0;
      commit_rd_reg    <= 5'd0;
      commit_data_reg  <= 32'd0;
      instret_reg      <= 64'd0;
      illegal_op_reg   <= 1'b0;
    end else begin
      commit_valid_reg <= retire;
      commit_rd_reg    <= wr_en ? rd : 5'd0;
      commit_data_reg  <= wr_en ? wb_value : 32'd0;
      if (retire) begin
        instret_reg <= instret_reg + 64'd1;
      end
      if (wb.wb_valid && !legal_op) begin
        illegal_op_reg <= 1'b1;
      end
    end
  end

  assign wb.commit_valid = commit_valid_reg;
  assign wb.commit_rd    = commit_rd_reg;
  assign wb.commit_data  = commit_data_reg;
  assign wb.instret      = instret_reg;
  assign wb.illegal_op   = illegal_op_reg;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: behavioural register-file/commit model checked
// every falling edge, plus hand-computed expectations along the directed sequence.
module tb_writeback_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  writeback_stage_if wb ();
  writeback_stage dut (.clk(clk), .rst(rst), .wb(wb));

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  logic [31:0] m_regs [32];
  logic [63:0] m_instret = 64'd0;
  logic        m_illegal = 1'b0;
  logic        m_cvalid  = 1'b0;
  logic [4:0]  m_crd     = 5'd0;
  logic [31:0] m_cdata   = 32'd0;
  logic        preset_pending = 1'b0;

  // 0 = illegal, 1 = retires without write, 2 = writes ALU result, 3 = writes load data
  function automatic int op_class(input logic [31:0] ir);
    case (ir[6:0])
      7'h03:                                     return 3;
      7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67: return 2;
      7'h23, 7'h63, 7'h73:                       return 1;
      default:                                   return 0;
    endcase
  endfunction

  function automatic logic [31:0] result_of(input logic [31:0] ir, input logic [31:0] dout,
                                            input logic [31:0] alu);
    return (op_class(ir) == 3) ? dout : alu;
  endfunction

  function automatic logic will_write(input logic r, input logic v, input logic [31:0] ir);
    return r && v && (op_class(ir) >= 2) && (ir[11:7] != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (will_write(rst, wb.wb_valid, wb.IR) && (wb.IR[11:7] == addr))
      return result_of(wb.IR, wb.dataout, wb.ALUResult);
    return m_regs[addr];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_instret <= 64'd0;
      m_illegal <= 1'b0;
      m_cvalid  <= 1'b0;
      m_crd     <= 5'd0;
      m_cdata   <= 32'd0;
    end else if (wb.wb_valid && op_class(wb.IR) != 0) begin
      m_instret <= (preset_pending ? 64'hFFFF_FFFF_FFFF_FFFF : m_instret) + 64'd1;
      m_cvalid  <= 1'b1;
      if (will_write(1'b1, 1'b1, wb.IR)) begin
        m_regs[wb.IR[11:7]] <= result_of(wb.IR, wb.dataout, wb.ALUResult);
        m_crd   <= wb.IR[11:7];
        m_cdata <= result_of(wb.IR, wb.dataout, wb.ALUResult);
      end else begin
        m_crd   <= 5'd0;
        m_cdata <= 32'd0;
      end
    end else begin
      m_cvalid <= 1'b0;
      m_crd    <= 5'd0;
      m_cdata  <= 32'd0;
      if (preset_pending) m_instret <= 64'hFFFF_FFFF_FFFF_FFFF;
      if (wb.wb_valid) m_illegal <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("rd1", 64'(wb.RD1), 64'(exp_rd(wb.RS1_addr)));
    chk("rd2", 64'(wb.RD2), 64'(exp_rd(wb.RS2_addr)));
    chk("commit_valid", 64'(wb.commit_valid), 64'(m_cvalid));
    chk("commit_rd", 64'(wb.commit_rd), 64'(m_crd));
    chk("commit_data", 64'(wb.commit_data), 64'(m_cdata));
    chk("instret", wb.instret, m_instret);
    chk("illegal_op", 64'(wb.illegal_op), 64'(m_illegal));
  end

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] dout,
                       input logic [31:0] alu, input logic [4:0] a1, input logic [4:0] a2);
    wb.wb_valid  = v;
    wb.IR        = ir;
    wb.dataout   = dout;
    wb.ALUResult = alu;
    wb.RS1_addr  = a1;
    wb.RS2_addr  = a2;
    txn++;
    $display("txn %0d: rst=%0b v=%0b ir=%h dout=%h alu=%h rs1=%0d rs2=%0d",
             txn, rst, v, ir, dout, alu, a1, a2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ir;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd31);
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    mid();
    chk("reset_rd1", 64'(wb.RD1), 64'd0);
    chk("reset_rd2", 64'(wb.RD2), 64'd0);
    chk("reset_instret", wb.instret, 64'd0);
    chk("reset_illegal", 64'(wb.illegal_op), 64'd0);
    chk("reset_commit_valid", 64'(wb.commit_valid), 64'd0);
    tick();

    // addi x5, x0, 10
    drive(1'b1, 32'h00A00293, 32'd0, 32'h0000000A, 5'd5, 5'd0);
    mid();
    chk("bypass_x5", 64'(wb.RD1), 64'h0A);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
    mid();
    chk("addi_commit_valid", 64'(wb.commit_valid), 64'd1);
    chk("addi_commit_rd", 64'(wb.commit_rd), 64'd5);
    chk("addi_commit_data", 64'(wb.commit_data), 64'h0A);
    chk("addi_instret", wb.instret, 64'd1);
    chk("stored_x5", 64'(wb.RD1), 64'h0A);
    tick();

    // lw x7 then jal x1
    drive(1'b1, 32'h0000A383, 32'hDEADBEEF, 32'h00000100, 5'd7, 5'd0);
    tick();
    drive(1'b1, 32'h000000EF, 32'd0, 32'h00000024, 5'd7, 5'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd7, 5'd1);
    mid();
    chk("load_x7", 64'(wb.RD1), 64'hDEADBEEF);
    chk("jal_x1", 64'(wb.RD2), 64'h24);
    chk("jal_instret", wb.instret, 64'd3);
    chk("jal_commit_rd", 64'(wb.commit_rd), 64'd1);
    chk("jal_commit_data", 64'(wb.commit_data), 64'h24);
    tick();

    // addi x0 then store
    drive(1'b1, 32'h05500013, 32'd0, 32'h00000055, 5'd0, 5'd0);
    mid();
    chk("x0_read", 64'(wb.RD1), 64'd0);
    tick();
    drive(1'b1, 32'h0020A023, 32'd0, 32'h00001234, 5'd5, 5'd7);
    mid();
    chk("x0_commit_valid", 64'(wb.commit_valid), 64'd1);
    chk("x0_commit_rd", 64'(wb.commit_rd), 64'd0);
    chk("x0_commit_data", 64'(wb.commit_data), 64'd0);
    chk("x0_instret", wb.instret, 64'd4);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd7);
    mid();
    chk("store_commit_valid", 64'(wb.commit_valid), 64'd1);
    chk("store_commit_data", 64'(wb.commit_data), 64'd0);
    chk("store_instret", wb.instret, 64'd5);
    chk("store_x5_kept", 64'(wb.RD1), 64'h0A);
    chk("store_x7_kept", 64'(wb.RD2), 64'hDEADBEEF);
    tick();

    // illegal opcode
    drive(1'b1, 32'hFFFFFFFF, 32'd0, 32'h00000077, 5'd31, 5'd5);
    mid();
    chk("illegal_no_bypass", 64'(wb.RD1), 64'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd31, 5'd5);
    mid();
    chk("illegal_flag", 64'(wb.illegal_op), 64'd1);
    chk("illegal_instret", wb.instret, 64'd5);
    chk("illegal_commit_valid", 64'(wb.commit_valid), 64'd0);
    chk("illegal_x31", 64'(wb.RD1), 64'd0);
    tick();

    for (int i = 1; i <= 10; i++) begin
      ir = {20'd0, 5'(i), 7'h13};
      drive(1'b1, ir, 32'd0, 32'(i * 3), 5'(i), 5'd0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd9, 5'd10);
    mid();
    chk("sticky_illegal", 64'(wb.illegal_op), 64'd1);
    chk("loop_instret", wb.instret, 64'd15);
    chk("loop_x9", 64'(wb.RD1), 64'd27);
    chk("loop_x10", 64'(wb.RD2), 64'd30);
    tick();

    // bubble carrying a writing instruction
    drive(1'b0, {20'd0, 5'd9, 7'h13}, 32'd0, 32'h00000BAD, 5'd9, 5'd0);
    mid();
    chk("bubble_no_bypass", 64'(wb.RD1), 64'd27);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd9, 5'd0);
    mid();
    chk("bubble_x9", 64'(wb.RD1), 64'd27);
    chk("bubble_instret", wb.instret, 64'd15);
    chk("bubble_commit_valid", 64'(wb.commit_valid), 64'd0);

    // instret wrap
    force dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    preset_pending = 1'b1;
    #1;
    release dut.instret_reg;
    drive(1'b1, {20'd0, 5'd2, 7'h13}, 32'd0, 32'h00000001, 5'd2, 5'd0);
    tick();
    preset_pending = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd2, 5'd0);
    mid();
    chk("wrap_instret", wb.instret, 64'd0);
    chk("wrap_x2", 64'(wb.RD1), 64'd1);
    chk("wrap_commit_rd", 64'(wb.commit_rd), 64'd2);
    chk("illegal_before_reset", 64'(wb.illegal_op), 64'd1);
    tick();

    // asynchronous reset between edges
    drive(1'b1, {20'd0, 5'd3, 7'h13}, 32'd0, 32'h00000033, 5'd5, 5'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rd1", 64'(wb.RD1), 64'd0);
    chk("async_rd2", 64'(wb.RD2), 64'd0);
    chk("async_instret", wb.instret, 64'd0);
    chk("async_commit_valid", 64'(wb.commit_valid), 64'd0);
    chk("async_commit_rd", 64'(wb.commit_rd), 64'd0);
    chk("async_commit_data", 64'(wb.commit_data), 64'd0);
    chk("async_illegal", 64'(wb.illegal_op), 64'd0);
    tick();
    tick();
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 5'd3, 5'd5);
    mid();
    chk("lost_x3", 64'(wb.RD1), 64'd0);
    chk("lost_x5", 64'(wb.RD2), 64'd0);
    chk("lost_instret", wb.instret, 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
